// File: rtl/plot_receiver_pkg.sv
// Shared display definitions: default frame geometry, frame-memory address
// width, colour width, the receiver FSM state encoding and the queued pixel
// record. Imported by every display block.
package plot_receiver_pkg;

  localparam int unsigned DISPLAY_WIDTH  = 160;
  localparam int unsigned DISPLAY_HEIGHT = 120;
  localparam int unsigned ADDR_W         = 15;
  localparam int unsigned COLOUR_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // Row-major linear frame address.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x,
                                                   input logic [7:0] y,
                                                   input int unsigned width);
    return ADDR_W'(32'(y) * width + 32'(x));
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Pixel FIFO between the plot producer and the frame-memory writer.
// Ports:
//   clock, resetn       - clock, asynchronous active-low reset
//   push, push_data     - enqueue one pixel record (never asserted when full)
//   pop                 - dequeue the head (never asserted when empty)
//   head                - current head entry
//   next_head           - entry that becomes head after a pop this cycle
//   full, empty, last   - occupancy flags (last = exactly one entry)
module plot_fifo
  import plot_receiver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   push,
  input  logic   pop,
  input  pixel_t push_data,
  output pixel_t head,
  output pixel_t next_head,
  output logic   full,
  output logic   empty,
  output logic   last
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pixel_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  // With a single entry, the only candidate for the post-pop head is the
  // pixel being pushed in the same cycle.
  assign next_head = (count == CNT_W'(1)) ? push_data : mem[rd_ptr + PTR_W'(1)];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign last  = (count == CNT_W'(1));

endmodule

// File: rtl/plot_receiver.sv
// Receives plotted pixels, range-checks them, queues them and writes them to
// frame memory with a held write request; also sweeps the whole frame to
// colour 0 on a clear request.
// Ports:
//   clock, resetn               - clock, asynchronous active-low reset
//   in_x, in_y, in_colour, plot - pixel from producer, valid when plot
//   in_ready                    - pixel accepted when plot && in_ready
//   clear                       - one-cycle request to blank the frame
//   mem_addr, mem_data, mem_we  - frame memory write, held until mem_ready
//   mem_ready                   - memory accepts the write this cycle
//   drop_count                  - saturating count of out-of-range pixels
//   clearing                    - high while the clear sweep runs
module plot_receiver
  import plot_receiver_pkg::*;
#(
  parameter int unsigned WIDTH  = DISPLAY_WIDTH,
  parameter int unsigned HEIGHT = DISPLAY_HEIGHT,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [7:0]          in_x,
  input  logic [7:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                plot,
  output logic                in_ready,
  input  logic                clear,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [7:0]          drop_count,
  output logic                clearing
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t            state;
  logic              clear_pend;
  logic [ADDR_W-1:0] sweep;

  logic   accept;
  logic   in_range;
  logic   push;
  logic   pop;
  pixel_t push_data;
  pixel_t head;
  pixel_t next_head;
  logic   full;
  logic   empty;
  logic   last;

  assign in_ready  = !full;
  assign accept    = plot && in_ready;
  assign in_range  = (32'(in_x) < WIDTH) && (32'(in_y) < HEIGHT);
  assign push      = accept && in_range;
  assign push_data = '{addr: pixel_addr(in_x, in_y, WIDTH), colour: in_colour};
  assign pop       = (state == ST_WRITE) && mem_ready;

  plot_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .head     (head),
    .next_head(next_head),
    .full     (full),
    .empty    (empty),
    .last     (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (accept && !in_range && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      clearing   <= 1'b0;
      clear_pend <= 1'b0;
      sweep      <= '0;
    end else begin
      // Pending flag drops when the sweep starts; pulses during the sweep
      // are swallowed.
      if (state == ST_IDLE && clear_pend)
        clear_pend <= 1'b0;
      else if (clear && state != ST_CLEAR)
        clear_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (clear_pend) begin
            state    <= ST_CLEAR;
            clearing <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= '0;
            sweep    <= '0;
          end else if (!empty) begin
            state    <= ST_WRITE;
            mem_we   <= 1'b1;
            mem_addr <= head.addr;
            mem_data <= head.colour;
          end
        end

        ST_WRITE: begin
          if (mem_ready) begin
            // Outputs are registered, so the entry after the popped head is
            // loaded on the same edge as the pop.
            if (clear_pend || (last && !push)) begin
              state    <= ST_IDLE;
              mem_we   <= 1'b0;
              mem_addr <= '0;
              mem_data <= '0;
            end else begin
              mem_addr <= next_head.addr;
              mem_data <= next_head.colour;
            end
          end
        end

        ST_CLEAR: begin
          if (mem_ready) begin
            if (sweep == LAST_ADDR) begin
              state    <= ST_IDLE;
              clearing <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= '0;
              sweep    <= '0;
            end else begin
              sweep    <= sweep + ADDR_W'(1);
              mem_addr <= sweep + ADDR_W'(1);
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          mem_we   <= 1'b0;
          clearing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plot_receiver.sv
module tb_plot_receiver;

  logic        clock = 1'b0;
  logic        resetn;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [2:0]  in_colour;
  logic        plot;
  logic        in_ready;
  logic        clear;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic [7:0]  drop_count;
  logic        clearing;

  int unsigned checks = 0;
  int unsigned errors = 0;

  plot_receiver #(
    .WIDTH (160),
    .HEIGHT(120),
    .DEPTH (4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_colour (in_colour),
    .plot      (plot),
    .in_ready  (in_ready),
    .clear     (clear),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .drop_count(drop_count),
    .clearing  (clearing)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        clr;
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  int unsigned clr_cycles = 0;

  // Records every accepted memory write, sampled mid-cycle.
  always @(negedge clock) begin
    #1;
    if (resetn === 1'b1) begin
      if (clearing) clr_cycles++;
      if (mem_we && mem_ready) wr_q.push_back('{clearing, mem_addr, mem_data});
    end
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    bit          ok;
    int unsigned addr;
    int unsigned drop;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_writes(input string name, input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (wr_q.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    #2;
    check(name, wr_q.size() >= n, 1);
  endtask

  task automatic drive_px(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    plot = 1'b1; in_x = x; in_y = y; in_colour = c;
  endtask

  initial begin
    int unsigned bad;
    logic [7:0]  bp_x[5];
    logic [7:0]  bp_y[5];
    int unsigned bp_addr[5];
    bit          bp_rdy[5];
    int unsigned k;

    vecs[0] = '{8'd5,   8'd2,   3'd5, 1'b1, 325,   0};
    vecs[1] = '{8'd160, 8'd0,   3'd1, 1'b0, 0,     1};
    vecs[2] = '{8'd0,   8'd120, 3'd2, 1'b0, 0,     2};
    vecs[3] = '{8'd0,   8'd0,   3'd1, 1'b1, 0,     2};
    vecs[4] = '{8'd159, 8'd119, 3'd7, 1'b1, 19199, 2};
    vecs[5] = '{8'd10,  8'd1,   3'd2, 1'b1, 170,   2};
    vecs[6] = '{8'd255, 8'd255, 3'd3, 1'b0, 0,     3};
    vecs[7] = '{8'd159, 8'd0,   3'd4, 1'b1, 159,   3};
    vecs[8] = '{8'd0,   8'd119, 3'd6, 1'b1, 19040, 3};

    bp_x    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    bp_y    = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    bp_addr = '{1, 2, 163, 324, 485};
    bp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    resetn = 1'b0; plot = 1'b0; clear = 1'b0; mem_ready = 1'b1;
    in_x = '0; in_y = '0; in_colour = '0;

    #3;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_clearing", clearing, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;

    // Single pixels, one at a time, memory always ready.
    foreach (vecs[i]) begin
      @(negedge clock);
      drive_px(vecs[i].x, vecs[i].y, vecs[i].c);
      @(posedge clock); #1;
      check($sformatf("v%0d_we_at_accept", i), mem_we, 0);
      @(negedge clock);
      plot = 1'b0;
      @(posedge clock); #1;
      check($sformatf("v%0d_we", i), mem_we, vecs[i].ok);
      if (vecs[i].ok) begin
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
        check($sformatf("v%0d_data", i), mem_data, vecs[i].c);
      end
      check($sformatf("v%0d_drop", i), drop_count, vecs[i].drop);
      @(posedge clock); #1;
      check($sformatf("v%0d_we_after", i), mem_we, 0);
    end

    // Drop counter saturation.
    @(negedge clock);
    drive_px(8'd200, 8'd0, 3'd1);
    for (int i = 0; i < 300; i++) @(posedge clock);
    @(negedge clock);
    plot = 1'b0;
    check("drop_saturate", drop_count, 255);
    check("drop_no_write", mem_we, 0);

    // Backpressure: four accepts fill the FIFO, the fifth is refused.
    mem_ready = 1'b0;
    wr_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive_px(bp_x[i], bp_y[i], 3'(i + 1));
      check($sformatf("bp_in_ready%0d", i), in_ready, bp_rdy[i]);
    end
    @(negedge clock);
    plot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("bp_hold_we%0d", i), mem_we, 1);
      check($sformatf("bp_hold_addr%0d", i), mem_addr, bp_addr[0]);
    end
    mem_ready = 1'b1;
    wait_writes("bp_timeout", 4, 20);
    repeat (5) @(posedge clock);
    #2;
    check("bp_count", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_q.size()) begin
        check($sformatf("bp_addr%0d", i), wr_q[i].addr, bp_addr[i]);
        check($sformatf("bp_data%0d", i), wr_q[i].data, i + 1);
      end
    end

    // Full-frame clear with memory always ready.
    @(negedge clock);
    wr_q.delete(); clr_cycles = 0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    wait_writes("clr_timeout", 19200, 19400);
    repeat (4) @(posedge clock);
    #2;
    check("clr_cycles", clr_cycles, 19200);
    check("clr_count", wr_q.size(), 19200);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i].addr != 15'(i) || wr_q[i].data != 3'd0 || !wr_q[i].clr) bad++;
    check("clr_sweep_bad", bad, 0);
    check("clr_end_we", mem_we, 0);
    check("clr_end_clearing", clearing, 0);

    // Clear during WRITE with three queued pixels.
    @(negedge clock);
    mem_ready = 1'b0;
    drive_px(8'd7, 8'd7, 3'd1);
    @(negedge clock); drive_px(8'd8, 8'd8, 3'd2);
    @(negedge clock); drive_px(8'd9, 8'd9, 3'd3);
    @(negedge clock); plot = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    wr_q.delete(); clr_cycles = 0;
    mem_ready = 1'b1;
    wait_writes("cw_timeout", 19203, 19500);
    repeat (4) @(posedge clock);
    #2;
    check("cw_count", wr_q.size(), 19203);
    check("cw_clr_cycles", clr_cycles, 19200);
    if (wr_q.size() == 19203) begin
      check("cw_first_addr", wr_q[0].addr, 1127);
      check("cw_first_clr", wr_q[0].clr, 0);
      bad = 0;
      for (int i = 1; i <= 19200; i++)
        if (wr_q[i].addr != 15'(i - 1) || wr_q[i].data != 3'd0 || !wr_q[i].clr) bad++;
      check("cw_sweep_bad", bad, 0);
      check("cw_b_addr", wr_q[19201].addr, 1288);
      check("cw_b_data", wr_q[19201].data, 2);
      check("cw_c_addr", wr_q[19202].addr, 1449);
      check("cw_c_data", wr_q[19202].data, 3);
    end

    // Reset in the middle of a sweep, with a pixel queued behind it.
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    k = 0;
    while (!(clearing && mem_addr == 15'd99) && k < 400) begin
      @(negedge clock);
      k++;
    end
    check("rc_reach99", k < 400, 1);
    drive_px(8'd1, 8'd1, 3'd1);
    check("rc_in_ready", in_ready, 1);
    @(negedge clock);
    plot = 1'b0;
    check("rc_addr100", mem_addr, 100);
    resetn = 1'b0;
    #1;
    check("rc_we", mem_we, 0);
    check("rc_clearing", clearing, 0);
    check("rc_addr", mem_addr, 0);
    check("rc_drop", drop_count, 0);
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    wr_q.delete();
    repeat (30) @(posedge clock);
    #2;
    check("rc_no_writes", wr_q.size(), 0);
    check("rc_idle_we", mem_we, 0);
    check("rc_idle_clearing", clearing, 0);
    check("rc_idle_drop", drop_count, 0);
    check("rc_idle_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
